// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: classifies up to two committed instructions per cycle,
// tags each one with a sequence number and a loss flag, and queues the records
// for the tracer, which drains one record per cycle over valid/ready.
module commit_trace_buffer #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned XLEN            = 64,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [NR_COMMIT_PORTS-1:0]            commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  commit_pc_i,
  input  logic [NR_COMMIT_PORTS-1:0][31:0]      commit_instr_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0]       commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  commit_wdata_i,
  output logic                                  trace_valid_o,
  input  logic                                  trace_ready_i,
  output logic [XLEN-1:0]                       trace_pc_o,
  output logic [31:0]                           trace_instr_o,
  output logic [4:0]                            trace_rd_o,
  output logic [XLEN-1:0]                       trace_wdata_o,
  output logic [3:0]                            trace_class_o,
  output logic [15:0]                           trace_seq_o,
  output logic                                  trace_lost_o,
  output logic [15:0]                           drop_cnt_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  // Instruction classes
  localparam logic [3:0] CLS_OTHER     = 4'd0;
  localparam logic [3:0] CLS_ALU       = 4'd1;
  localparam logic [3:0] CLS_MULDIV    = 4'd2;
  localparam logic [3:0] CLS_LOAD      = 4'd3;
  localparam logic [3:0] CLS_STORE     = 4'd4;
  localparam logic [3:0] CLS_BRANCH    = 4'd5;
  localparam logic [3:0] CLS_JUMP      = 4'd6;
  localparam logic [3:0] CLS_CSR       = 4'd7;
  localparam logic [3:0] CLS_SYSTEM    = 4'd8;
  localparam logic [3:0] CLS_FENCE     = 4'd9;
  localparam logic [3:0] CLS_FP        = 4'd10;
  localparam logic [3:0] CLS_SUBFP     = 4'd11;
  localparam logic [3:0] CLS_SUBFP_MEM = 4'd12;
  localparam logic [3:0] CLS_AMO       = 4'd13;

  // Major opcodes (sub-FP8 arithmetic lives in custom-2, its memory ops in custom-1)
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_STORE_FP = 7'b0100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_FP       = 7'b1010011;
  localparam logic [6:0] OP_MADD     = 7'b1000011;
  localparam logic [6:0] OP_MSUB     = 7'b1000111;
  localparam logic [6:0] OP_NMSUB    = 7'b1001011;
  localparam logic [6:0] OP_NMADD    = 7'b1001111;
  localparam logic [6:0] OP_SUBFP    = 7'b1011011;
  localparam logic [6:0] OP_SUBFP_MEM = 7'b0101011;
  localparam logic [6:0] OP_AMO      = 7'b0101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic [3:0]      cls;
    logic [15:0]     seq;
    logic            lost;
  } rec_t;

  // Map raw instruction bits to a trace class
  function automatic logic [3:0] classify(input logic [31:0] ins);
    logic [3:0] c;
    logic [2:0] f3;
    c  = CLS_OTHER;
    f3 = ins[15:13];
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        OP_LUI, OP_AUIPC, OP_IMM, OP_IMM32:      c = CLS_ALU;
        OP_OP, OP_OP32:                          c = (ins[31:25] == 7'b0000001) ? CLS_MULDIV : CLS_ALU;
        OP_LOAD, OP_LOAD_FP:                     c = CLS_LOAD;
        OP_STORE, OP_STORE_FP:                   c = CLS_STORE;
        OP_BRANCH:                               c = CLS_BRANCH;
        OP_JAL, OP_JALR:                         c = CLS_JUMP;
        OP_SYSTEM:                               c = (ins[14:12] != 3'b000) ? CLS_CSR : CLS_SYSTEM;
        OP_MISC_MEM:                             c = CLS_FENCE;
        OP_FP, OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD: c = CLS_FP;
        OP_SUBFP:                                c = CLS_SUBFP;
        OP_SUBFP_MEM:                            c = CLS_SUBFP_MEM;
        OP_AMO:                                  c = CLS_AMO;
        default:                                 c = CLS_OTHER;
      endcase
    end else if (ins[1:0] == 2'b00) begin
      if (ins[15:0] == 16'h0000) begin
        c = CLS_OTHER;
      end else begin
        case (f3)
          3'b000:                 c = CLS_ALU;
          3'b001, 3'b010, 3'b011: c = CLS_LOAD;
          3'b100:                 c = CLS_OTHER;
          default:                c = CLS_STORE;
        endcase
      end
    end else if (ins[1:0] == 2'b01) begin
      case (f3)
        3'b001:         c = (XLEN == 64) ? CLS_ALU : CLS_JUMP;
        3'b101:         c = CLS_JUMP;
        3'b110, 3'b111: c = CLS_BRANCH;
        default:        c = CLS_ALU;
      endcase
    end else begin
      case (f3)
        3'b000:                 c = CLS_ALU;
        3'b001, 3'b010, 3'b011: c = CLS_LOAD;
        3'b100: begin
          if (ins[6:2] != 5'd0)            c = CLS_ALU;
          else if (ins[15:0] == 16'h9002)  c = CLS_SYSTEM;
          else if (ins[11:7] != 5'd0)      c = CLS_JUMP;
          else                             c = CLS_OTHER;
        end
        default:                c = CLS_STORE;
      endcase
    end
    return c;
  endfunction

  rec_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [15:0]       seq;
  logic              lost_pending;
  logic [15:0]       drop_cnt;

  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  free;
  logic              empty;
  logic              full;
  logic              pop;
  logic [1:0]        n_valid;
  logic [1:0]        push_n;
  logic [1:0]        drop_n;
  logic              sel0;
  rec_t              rec0;
  rec_t              rec1;
  logic [16:0]       drop_sum;
  logic [15:0]       drop_next;
  logic              lost_next;
  rec_t              head;

  // Occupancy from registered pointers; a same-cycle pop never frees space
  always_comb begin
    count = wr_ptr - rd_ptr;
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    free  = full ? '0 : (PTR_W'(DEPTH) - count);
    pop   = ~empty & trace_ready_i;
  end

  // Admission decision, record assembly and bookkeeping updates
  always_comb begin
    n_valid = 2'(commit_valid_i[0]) + 2'(commit_valid_i[1]);
    push_n  = 2'd0;
    drop_n  = 2'd0;
    if (flush_i) begin
      push_n = 2'd0;
      drop_n = 2'd0;
    end else if (free >= PTR_W'(n_valid)) begin
      push_n = n_valid;
    end else if (free == PTR_W'(1)) begin
      push_n = 2'd1;
      drop_n = 2'd1;
    end else begin
      drop_n = n_valid;
    end

    // First pushed slot is the lowest valid port; second slot is always port 1
    sel0       = ~commit_valid_i[0];
    rec0.pc    = commit_pc_i[sel0];
    rec0.instr = commit_instr_i[sel0];
    rec0.rd    = commit_rd_i[sel0];
    rec0.wdata = commit_wdata_i[sel0];
    rec0.cls   = classify(commit_instr_i[sel0]);
    rec0.seq   = seq;
    rec0.lost  = lost_pending;

    rec1.pc    = commit_pc_i[1];
    rec1.instr = commit_instr_i[1];
    rec1.rd    = commit_rd_i[1];
    rec1.wdata = commit_wdata_i[1];
    rec1.cls   = classify(commit_instr_i[1]);
    rec1.seq   = seq + 16'd1;
    rec1.lost  = 1'b0;

    drop_sum  = {1'b0, drop_cnt} + 17'(drop_n);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    lost_next = lost_pending;
    if (drop_n != 2'd0)      lost_next = 1'b1;
    else if (push_n != 2'd0) lost_next = 1'b0;
  end

  // Pointers, sequence counter, loss flag and drop counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      seq          <= '0;
      lost_pending <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      seq          <= seq + 16'(n_valid);
      lost_pending <= lost_next;
      drop_cnt     <= drop_next;
      if (flush_i) begin
        rd_ptr <= wr_ptr;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(push_n);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Record storage, written in port order
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_n != 2'd0) mem[wr_ptr[AW-1:0]] <= rec0;
      if (push_n == 2'd2) mem[wr_ptr[AW-1:0] + AW'(1)] <= rec1;
    end
  end

  // Head record straight from storage
  always_comb begin
    head          = mem[rd_ptr[AW-1:0]];
    trace_valid_o = ~empty;
    trace_pc_o    = head.pc;
    trace_instr_o = head.instr;
    trace_rd_o    = head.rd;
    trace_wdata_o = head.wdata;
    trace_class_o = head.cls;
    trace_seq_o   = head.seq;
    trace_lost_o  = head.lost;
    drop_cnt_o    = drop_cnt;
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer.
module tb_commit_trace_buffer;

  localparam int unsigned NP    = 2;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] ADDI  = 32'h00500093;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       flush = 1'b0;
  logic [NP-1:0]              commit_valid = '0;
  logic [NP-1:0][XLEN-1:0]    commit_pc = '0;
  logic [NP-1:0][31:0]        commit_instr = '0;
  logic [NP-1:0][4:0]         commit_rd = '0;
  logic [NP-1:0][XLEN-1:0]    commit_wdata = '0;
  logic                       trace_valid;
  logic                       trace_ready = 1'b0;
  logic [XLEN-1:0]            trace_pc;
  logic [31:0]                trace_instr;
  logic [4:0]                 trace_rd;
  logic [XLEN-1:0]            trace_wdata;
  logic [3:0]                 trace_class;
  logic [15:0]                trace_seq;
  logic                       trace_lost;
  logic [15:0]                drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sw_ins [13] = '{32'h00009002, 32'h00008082, 32'h00004501, 32'h0000E008,
                               32'h00000000, 32'h0000005B, 32'h0000202B, 32'h02208033,
                               32'h30002573, 32'h0000000F, 32'h0020B02F, 32'h00000053,
                               32'h00000073};
  logic [3:0]  sw_cls [13] = '{4'd8, 4'd6, 4'd1, 4'd4, 4'd0, 4'd11, 4'd12, 4'd2,
                               4'd7, 4'd9, 4'd13, 4'd10, 4'd8};

  commit_trace_buffer #(.NR_COMMIT_PORTS(NP), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .commit_valid_i (commit_valid),
    .commit_pc_i    (commit_pc),
    .commit_instr_i (commit_instr),
    .commit_rd_i    (commit_rd),
    .commit_wdata_i (commit_wdata),
    .trace_valid_o  (trace_valid),
    .trace_ready_i  (trace_ready),
    .trace_pc_o     (trace_pc),
    .trace_instr_o  (trace_instr),
    .trace_rd_o     (trace_rd),
    .trace_wdata_o  (trace_wdata),
    .trace_class_o  (trace_class),
    .trace_seq_o    (trace_seq),
    .trace_lost_o   (trace_lost),
    .drop_cnt_o     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int p, input logic [31:0] ins, input logic [63:0] pc);
    commit_valid[p] = 1'b1;
    commit_instr[p] = ins;
    commit_pc[p]    = pc;
    commit_rd[p]    = ins[11:7];
    commit_wdata[p] = ~pc;
  endtask

  task automatic idle();
    commit_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] s, input logic l, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(trace_valid), 64'd1);
    chk({tag, "_seq"},   64'(trace_seq),   64'(s));
    chk({tag, "_lost"},  64'(trace_lost),  64'(l));
    chk({tag, "_pc"},    trace_pc,         pc);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_drop",  64'(drop_cnt),    64'd0);
    chk("rst_pc",    trace_pc,         64'd0);
    chk("rst_instr", 64'(trace_instr), 64'd0);
    chk("rst_class", 64'(trace_class), 64'd0);
    chk("rst_seq",   64'(trace_seq),   64'd0);

    // Single ALU commit
    trace_ready = 1'b1;
    put(0, ADDI, 64'h80000000);
    tick();
    idle();
    chk_head("alu", 16'd0, 1'b0, 64'h80000000);
    chk("alu_class", 64'(trace_class), 64'd1);
    chk("alu_rd",    64'(trace_rd),    64'd1);
    chk("alu_wdata", trace_wdata,      ~64'h80000000);
    chk("alu_instr", 64'(trace_instr), 64'h00500093);
    tick();
    chk("alu_drained", 64'(trace_valid), 64'd0);

    // Dual commit ld/sd, port order preserved
    do_reset();
    put(0, 32'h00003083, 64'h1000);
    put(1, 32'h0000B023, 64'h1004);
    tick();
    idle();
    chk_head("dual0", 16'd0, 1'b0, 64'h1000);
    chk("dual0_class", 64'(trace_class), 64'd3);
    tick();
    chk_head("dual1", 16'd1, 1'b0, 64'h1004);
    chk("dual1_class", 64'(trace_class), 64'd4);
    tick();
    chk("dual_drained", 64'(trace_valid), 64'd0);

    // Classification sweep, one commit per cycle streaming through
    do_reset();
    for (int i = 0; i < 13; i++) begin
      put(0, sw_ins[i], 64'h2000 + 64'(4 * i));
      tick();
      chk($sformatf("sweep%0d_class", i), 64'(trace_class), 64'(sw_cls[i]));
      chk($sformatf("sweep%0d_seq", i),   64'(trace_seq),   64'(i));
    end
    idle();
    tick();
    chk("sweep_drained", 64'(trace_valid), 64'd0);

    // Fill with ready low, drop a pair, then recover with lost flag
    do_reset();
    trace_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      put(0, ADDI, 64'h100 + 64'(8 * k));
      put(1, ADDI, 64'h104 + 64'(8 * k));
      tick();
      if (k == 0) chk_head("fill_first", 16'd0, 1'b0, 64'h100);
    end
    chk("full_drop0", 64'(drop_cnt), 64'd0);
    put(0, ADDI, 64'h120);
    put(1, ADDI, 64'h124);
    tick();
    idle();
    chk("full_drop2", 64'(drop_cnt), 64'd2);
    chk_head("full_hold", 16'd0, 1'b0, 64'h100);
    trace_ready = 1'b1;
    tick();
    chk_head("full_pop", 16'd1, 1'b0, 64'h104);
    trace_ready = 1'b0;
    put(0, ADDI, 64'h128);
    tick();
    idle();
    chk("full_drop_keep", 64'(drop_cnt), 64'd2);
    trace_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      chk_head($sformatf("full_drain%0d", k), 16'(k), 1'b0, 64'h100 + 64'(4 * k));
      tick();
    end
    chk_head("full_ninth", 16'd10, 1'b1, 64'h128);
    tick();
    chk("full_drained", 64'(trace_valid), 64'd0);

    // Full-minus-one with dual commit and simultaneous pop
    do_reset();
    trace_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(0, ADDI, 64'h300 + 64'(8 * k));
      put(1, ADDI, 64'h304 + 64'(8 * k));
      tick();
    end
    idle();
    put(0, ADDI, 64'h318);
    tick();
    trace_ready = 1'b1;
    put(0, ADDI, 64'h31C);
    put(1, ADDI, 64'h320);
    tick();
    idle();
    trace_ready = 1'b0;
    chk("fm1_drop1", 64'(drop_cnt), 64'd1);
    chk_head("fm1_head", 16'd1, 1'b0, 64'h304);
    put(0, ADDI, 64'h324);
    tick();
    idle();
    chk("fm1_drop_keep", 64'(drop_cnt), 64'd1);
    trace_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      chk_head($sformatf("fm1_drain%0d", k), 16'(k), 1'b0, 64'h300 + 64'(4 * k));
      tick();
    end
    chk_head("fm1_after_drop", 16'd9, 1'b1, 64'h324);
    tick();
    chk("fm1_drained", 64'(trace_valid), 64'd0);

    // Flush with 5 entries and concurrent commits
    do_reset();
    trace_ready = 1'b0;
    put(0, ADDI, 64'h400);
    put(1, ADDI, 64'h404);
    tick();
    put(0, ADDI, 64'h408);
    put(1, ADDI, 64'h40C);
    tick();
    idle();
    put(0, ADDI, 64'h410);
    tick();
    chk("flush_pre_valid", 64'(trace_valid), 64'd1);
    flush = 1'b1;
    put(0, ADDI, 64'h414);
    put(1, ADDI, 64'h418);
    tick();
    flush = 1'b0;
    idle();
    chk("flush_valid", 64'(trace_valid), 64'd0);
    chk("flush_drop",  64'(drop_cnt),    64'd0);
    put(0, ADDI, 64'h5000);
    tick();
    idle();
    chk_head("flush_next", 16'd7, 1'b0, 64'h5000);

    // Reset mid-operation overrides flush, commits and handshakes
    rst = 1'b1;
    flush = 1'b1;
    trace_ready = 1'b1;
    put(0, ADDI, 64'h6000);
    put(1, ADDI, 64'h6004);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    idle();
    chk("midrst_valid", 64'(trace_valid), 64'd0);
    chk("midrst_drop",  64'(drop_cnt),    64'd0);
    chk("midrst_pc",    trace_pc,         64'd0);
    put(0, ADDI, 64'h7000);
    tick();
    idle();
    chk_head("midrst_next", 16'd0, 1'b0, 64'h7000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
